dma_fifo_block: RTL and testbench

Parametrised block FIFO for the DMA data path: buffers one block of 2^AW words of DW bits between the SD/MMC-side producer and the CPU-side consumer. It supports one-shot mode, where a block is written and read exactly once and then re-armed by `init`, and ring mode, which runs continuously. Unlike the 512-byte one-shot FIFO it replaces, it guards against overflow and underflow, exports a fill level and a full flag, and drives a read-valid strobe.

---
 rtl/dma_fifo_pkg.sv | 12 +
 rtl/dma_fifo_dpram.sv | 48 ++++
 rtl/dma_fifo_block.sv | 148 ++++++++++++++
 tb/tb_dma_fifo_block.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_fifo_pkg.sv
// dma_fifo_pkg: shared constants for the DMA block FIFO.
//   DMA_FIFO_ONESHOT / DMA_FIFO_RING : values of the latched mode register
//   DMA_FIFO_DW / DMA_FIFO_AW        : default data and address widths
package dma_fifo_pkg;

  localparam logic DMA_FIFO_ONESHOT = 1'b0;
  localparam logic DMA_FIFO_RING    = 1'b1;

  localparam int DMA_FIFO_DW = 32'sd8;
  localparam int DMA_FIFO_AW = 32'sd9;

endpackage

// File: rtl/dma_fifo_dpram.sv
// dma_fifo_dpram: simple dual-port RAM, one write port and one registered
// read port with read enable. The read register is reset to 0; the array
// itself is not reset.
//   clk    : clock
//   rst_n  : synchronous active-low reset (read register only)
//   we     : write enable, waddr/wdata : write address/data
//   re     : read enable,  raddr       : read address
//   rdata  : registered read data, holds until the next re
module dma_fifo_dpram
  import dma_fifo_pkg::*;
#(
  parameter int DW = DMA_FIFO_DW,
  parameter int AW = DMA_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 32'sd1 << AW;

  logic [DW-1:0] mem_r [DEPTH];
  logic [DW-1:0] rdata_r;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds its value when re is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dma_fifo_block.sv
// dma_fifo_block: block FIFO for the DMA data path (2^AW words of DW bits),
// one-shot or ring mode, with fill level, full flag and read-valid strobe.
// Optional sticky overflow/underflow flags when DMA_FIFO_ERR_EN is defined.
//   clk, rst_n         : clock, synchronous active-low reset
//   init, ring         : synchronous re-arm; ring latched as mode on init
//   wr_stb, wd         : write strobe/data (accepted when !full)
//   rd_stb             : read strobe (accepted when !empty)
//   rd, rd_vld         : read data register, 1-cycle new-data pulse
//   wdone, wlast, rdone: one-shot block progress flags
//   empty, full, level : occupancy
//   err_ovf, err_unf   : sticky errors (DMA_FIFO_ERR_EN only)
module dma_fifo_block
  import dma_fifo_pkg::*;
#(
  parameter int DW = DMA_FIFO_DW,
  parameter int AW = DMA_FIFO_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          ring,
  input  logic          wr_stb,
  input  logic [DW-1:0] wd,
  input  logic          rd_stb,
  output logic [DW-1:0] rd,
  output logic          rd_vld,
  output logic          wdone,
  output logic          wlast,
  output logic          rdone,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
`ifdef DMA_FIFO_ERR_EN
  ,
  output logic          err_ovf,
  output logic          err_unf
`endif
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  logic        mode_r;
  logic        rd_vld_r;
  logic [AW:0] level_s;
  logic        empty_s;
  logic        full_s;
  logic        wdone_s;
  logic        rdone_s;
  logic        wlast_s;
  logic        wa_s;
  logic        ra_s;

  // Occupancy and block-progress flags decoded from the pointers and mode.
  always_comb begin
    level_s = wptr_r - rptr_r;
    empty_s = (level_s == '0);
    full_s  = 1'b0;
    wdone_s = 1'b0;
    rdone_s = 1'b0;
    wlast_s = 1'b0;
    if (mode_r == DMA_FIFO_RING) begin
      // level never exceeds 2^AW, so its MSB alone means full.
      full_s = level_s[AW];
    end else begin
      // One-shot: pointer MSB marks a finished block; once both are set the
      // block stays full and empty until re-armed.
      full_s  = wptr_r[AW];
      wdone_s = wptr_r[AW];
      rdone_s = rptr_r[AW];
      wlast_s = (&wptr_r[AW-1:0]) & ~wptr_r[AW];
    end
  end

  // init and reset override any strobe in the same cycle.
  assign wa_s = wr_stb & ~full_s  & ~init & rst_n;
  assign ra_s = rd_stb & ~empty_s & ~init & rst_n;

  // Pointers, mode and read-valid pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      mode_r   <= DMA_FIFO_ONESHOT;
      rd_vld_r <= 1'b0;
    end else if (init) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      mode_r   <= ring;
      rd_vld_r <= 1'b0;
    end else begin
      if (wa_s) begin
        wptr_r <= wptr_r + PTR_ONE;
      end
      if (ra_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      rd_vld_r <= ra_s;
    end
  end

`ifdef DMA_FIFO_ERR_EN
  logic err_ovf_r;
  logic err_unf_r;

  // Sticky error flags; init clears and wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      err_ovf_r <= 1'b0;
      err_unf_r <= 1'b0;
    end else begin
      if (wr_stb && full_s) begin
        err_ovf_r <= 1'b1;
      end
      if (rd_stb && empty_s) begin
        err_unf_r <= 1'b1;
      end
    end
  end

  assign err_ovf = err_ovf_r;
  assign err_unf = err_unf_r;
`endif

  dma_fifo_dpram #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wa_s),
    .waddr (wptr_r[AW-1:0]),
    .wdata (wd),
    .re    (ra_s),
    .raddr (rptr_r[AW-1:0]),
    .rdata (rd)
  );

  assign rd_vld = rd_vld_r;
  assign wdone  = wdone_s;
  assign rdone  = rdone_s;
  assign wlast  = wlast_s;
  assign empty  = empty_s;
  assign full   = full_s;
  assign level  = level_s;

endmodule

// File: tb/tb_dma_fifo_block.sv
// tb_dma_fifo_block: directed bench for dma_fifo_block (DW=8, AW=9) with a
// queue model for the ring-mode random phase.
module tb_dma_fifo_block;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int DEPTH = 512;

  logic          clk;
  logic          rst_n;
  logic          init;
  logic          ring;
  logic          wr_stb;
  logic [DW-1:0] wd;
  logic          rd_stb;
  logic [DW-1:0] rd;
  logic          rd_vld;
  logic          wdone;
  logic          wlast;
  logic          rdone;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
`ifdef DMA_FIFO_ERR_EN
  logic          err_ovf;
  logic          err_unf;
`endif

  int n_checks;
  int n_errors;
  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic [7:0] cnt;

  dma_fifo_block #(.DW(DW), .AW(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (init),
    .ring   (ring),
    .wr_stb (wr_stb),
    .wd     (wd),
    .rd_stb (rd_stb),
    .rd     (rd),
    .rd_vld (rd_vld),
    .wdone  (wdone),
    .wlast  (wlast),
    .rdone  (rdone),
    .empty  (empty),
    .full   (full),
    .level  (level)
`ifdef DMA_FIFO_ERR_EN
    ,
    .err_ovf(err_ovf),
    .err_unf(err_unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic r);
    init = 1'b1; ring = r;
    tick();
    init = 1'b0; ring = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; init = 1'b0; ring = 1'b0;
    wr_stb = 1'b0; rd_stb = 1'b0; wd = 8'h00;
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    chk("rst_rd", rd, 32'h0);
    chk("rst_rd_vld", rd_vld, 32'h0);
    chk("rst_wdone", wdone, 32'h0);
    chk("rst_rdone", rdone, 32'h0);
    chk("rst_wlast", wlast, 32'h0);
    chk("rst_empty", empty, 32'h1);
    chk("rst_full", full, 32'h0);
    chk("rst_level", level, 32'h0);
`ifdef DMA_FIFO_ERR_EN
    chk("rst_err_ovf", err_ovf, 32'h0);
    chk("rst_err_unf", err_unf, 32'h0);
`endif

    // Read on empty after reset is ignored
    rd_stb = 1'b1; tick(); rd_stb = 1'b0;
    chk("unf_rd", rd, 32'h0);
    chk("unf_rd_vld", rd_vld, 32'h0);
    chk("unf_level", level, 32'h0);
`ifdef DMA_FIFO_ERR_EN
    chk("unf_err_unf", err_unf, 32'h1);
`endif
    wr_stb = 1'b1; wd = 8'hA5; tick(); wr_stb = 1'b0;
    chk("wr1_level", level, 32'h1);
    chk("wr1_empty", empty, 32'h0);
    rd_stb = 1'b1; tick(); rd_stb = 1'b0;
    chk("rd1_data", rd, 32'hA5);
    chk("rd1_vld", rd_vld, 32'h1);
    chk("rd1_empty", empty, 32'h1);
    tick();
    chk("rd1_vld_pulse", rd_vld, 32'h0);
    chk("rd1_hold", rd, 32'hA5);

    // One-shot fill
    do_init(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0)   chk("os_wlast_first", wlast, 32'h0);
      if (i == 510) chk("os_wlast_510", wlast, 32'h0);
      if (i == 511) begin
        chk("os_wlast_511", wlast, 32'h1);
        chk("os_level_511", level, 32'd511);
      end
      wr_stb = 1'b1; wd = i[7:0]; tick();
    end
    wr_stb = 1'b0;
    chk("os_wdone", wdone, 32'h1);
    chk("os_full", full, 32'h1);
    chk("os_wlast_done", wlast, 32'h0);
    chk("os_level_full", level, 32'd512);
    wr_stb = 1'b1; wd = 8'hFF; tick(); wr_stb = 1'b0;
    chk("os_ovf_level", level, 32'd512);
`ifdef DMA_FIFO_ERR_EN
    chk("os_err_ovf", err_ovf, 32'h1);
`endif

    // One-shot drain
    for (int i = 0; i < DEPTH; i++) begin
      rd_stb = 1'b1; tick();
      chk("os_rd_data", rd, {24'h0, i[7:0]});
      chk("os_rd_vld", rd_vld, 32'h1);
    end
    rd_stb = 1'b0;
    chk("os_rdone_pre", rdone, 32'h1);
    tick();
    chk("os_rd_vld_end", rd_vld, 32'h0);
    chk("os_rdone", rdone, 32'h1);
    chk("os_empty", empty, 32'h1);
    chk("os_inert_full", full, 32'h1);
    wr_stb = 1'b1; rd_stb = 1'b1; wd = 8'h5A; tick();
    wr_stb = 1'b0; rd_stb = 1'b0;
    chk("os_inert_level", level, 32'h0);
    chk("os_inert_rd_vld", rd_vld, 32'h0);
    chk("os_inert_rd_hold", rd, 32'hFF);

    // Simultaneous strobes at level 2
    do_init(1'b0);
`ifdef DMA_FIFO_ERR_EN
    chk("init_clr_ovf", err_ovf, 32'h0);
`endif
    wr_stb = 1'b1; wd = 8'h11; tick();
    wd = 8'h22; tick();
    chk("sim_level_pre", level, 32'd2);
    wd = 8'h33; rd_stb = 1'b1; tick();
    wr_stb = 1'b0; rd_stb = 1'b0;
    chk("sim_level", level, 32'd2);
    chk("sim_rd", rd, 32'h11);
    chk("sim_rd_vld", rd_vld, 32'h1);

    // init mid-block at level 100 with a same-cycle write
    do_init(1'b0);
    rd_stb = 1'b1; tick(); rd_stb = 1'b0;
    for (int i = 0; i < 100; i++) begin
      wr_stb = 1'b1; wd = i[7:0]; tick();
    end
    wr_stb = 1'b0;
    chk("mid_level", level, 32'd100);
`ifdef DMA_FIFO_ERR_EN
    chk("mid_err_unf_set", err_unf, 32'h1);
`endif
    init = 1'b1; ring = 1'b1; wr_stb = 1'b1; wd = 8'hC3; tick();
    init = 1'b0; ring = 1'b0; wr_stb = 1'b0;
    chk("mid_init_level", level, 32'h0);
    chk("mid_init_empty", empty, 32'h1);
    chk("mid_init_rd_vld", rd_vld, 32'h0);
    chk("mid_init_rd_hold", rd, 32'h11);
`ifdef DMA_FIFO_ERR_EN
    chk("mid_init_err_unf", err_unf, 32'h0);
    chk("mid_init_err_ovf", err_ovf, 32'h0);
`endif

    // Ring mode (latched by the init above): fill to full
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 511) chk("ring_wlast_511", wlast, 32'h0);
      wr_stb = 1'b1; wd = i[7:0] ^ 8'h40; q.push_back(i[7:0] ^ 8'h40); tick();
    end
    wr_stb = 1'b0;
    chk("ring_full", full, 32'h1);
    chk("ring_level", level, 32'd512);
    chk("ring_wdone", wdone, 32'h0);
    wr_stb = 1'b1; rd_stb = 1'b1; wd = 8'hEE; tick();
    wr_stb = 1'b0; rd_stb = 1'b0;
    exp_d = q.pop_front();
    chk("ring_full_rw_rd", rd, {24'h0, exp_d});
    chk("ring_full_rw_level", level, 32'd511);
    chk("ring_full_rw_full", full, 32'h0);

    // Ring mode random traffic against a queue model
    cnt = 8'h80;
    for (int k = 0; k < 1000; k++) begin
      logic w, r, ea, er;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      ea = w && (q.size() != DEPTH);
      er = r && (q.size() != 0);
      wr_stb = w; rd_stb = r; wd = cnt;
      tick();
      if (er) begin
        exp_d = q.pop_front();
        chk("rnd_rd", rd, {24'h0, exp_d});
      end
      if (ea) q.push_back(cnt);
      cnt = cnt + 8'd1;
      chk("rnd_rd_vld", rd_vld, {31'h0, er});
      chk("rnd_level", level, q.size());
      chk("rnd_wdone", wdone, 32'h0);
      chk("rnd_rdone", rdone, 32'h0);
    end
    wr_stb = 1'b0; rd_stb = 1'b0;

    // Reset re-arms to one-shot and clears rd
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst2_rd", rd, 32'h0);
    chk("rst2_level", level, 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      wr_stb = 1'b1; wd = 8'h00; tick();
    end
    wr_stb = 1'b0;
    chk("rst2_oneshot_wdone", wdone, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
